// File: rtl/font_rom_pkg.sv
// Shared font ROM constants and the read-tag type used by the renderer, loader and arbiter.
package font_rom_pkg;
  localparam int ADDR_W         = 11;
  localparam int FONT_W         = 8;
  localparam int FONT_H         = 16;
  localparam int FONT_LINESHIFT = 4;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_R    = 2'd1,
    TAG_S    = 2'd2
  } e_rom_tag;
endpackage

// File: rtl/font_rom_arbiter_rom_req_fifo.sv
// Two-entry address FIFO holding secondary-client ROM reads until an idle ROM slot appears.
module rom_req_fifo #(
  parameter int W = font_rom_pkg::ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/font_rom_arbiter.sv
// Font ROM port arbiter: renderer reads issue immediately at fixed latency, secondary reads
// are queued and slotted into renderer idle cycles, with a sticky starvation flag.
module font_rom_arbiter #(
  parameter int ADDR_W     = font_rom_pkg::ADDR_W,
  parameter int FONT_W     = font_rom_pkg::FONT_W,
  parameter int ROM_LAT    = 2,
  parameter int STARVE_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_valid,
  output logic [FONT_W-1:0] r_q,
  input  logic              s_req,
  input  logic [ADDR_W-1:0] s_addr,
  output logic              s_ready,
  output logic              s_valid,
  output logic [FONT_W-1:0] s_q,
  input  logic              clr_starved,
  output logic              starved,
  output logic              rom_clk,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [FONT_W-1:0] rom_q
);
  import font_rom_pkg::*;

  localparam int               CNT_W    = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(STARVE_MAX);

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0] fifo_head;

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  e_rom_tag          tag_q [ROM_LAT+1];
  e_rom_tag          tag_d [ROM_LAT+1];
  e_rom_tag          issue_tag, ret_tag;
  logic              r_valid_q, r_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [FONT_W-1:0] r_q_q, r_q_d;
  logic [FONT_W-1:0] s_q_q, s_q_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              starved_q, starved_d;
  logic              run_q;

  // run_q keeps s_ready low until the first clock after reset release.
  assign fifo_push = s_req & s_ready;
  assign s_ready   = run_q & ~fifo_full;

  rom_req_fifo #(.W(ADDR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (s_addr),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    issue_tag  = TAG_NONE;
    rom_addr_d = rom_addr_q;
    fifo_pop   = 1'b0;
    if (r_req) begin
      issue_tag  = TAG_R;
      rom_addr_d = r_addr;
    end else if (!fifo_empty) begin
      issue_tag  = TAG_S;
      rom_addr_d = fifo_head;
      fifo_pop   = 1'b1;
    end

    // Stage 0 is aligned with rom_addr; the last stage lines up with valid rom_q.
    tag_d[0] = issue_tag;
    for (int i = 1; i <= ROM_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    ret_tag = tag_q[ROM_LAT];

    r_valid_d = (ret_tag == TAG_R);
    s_valid_d = (ret_tag == TAG_S);
    r_q_d     = r_valid_d ? rom_q : r_q_q;
    s_q_d     = s_valid_d ? rom_q : s_q_q;

    if (fifo_empty || (issue_tag == TAG_S)) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + CNT_W'(1);
    end else begin
      wait_d = wait_q;
    end

    starved_d = clr_starved ? 1'b0 : (starved_q | (wait_d == WAIT_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_q[i] <= TAG_NONE;
      end
      r_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      r_q_q     <= '0;
      s_q_q     <= '0;
      wait_q    <= '0;
      starved_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      for (int i = 0; i <= ROM_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
      r_valid_q <= r_valid_d;
      s_valid_q <= s_valid_d;
      r_q_q     <= r_q_d;
      s_q_q     <= s_q_d;
      wait_q    <= wait_d;
      starved_q <= starved_d;
      run_q     <= 1'b1;
    end
  end

  assign rom_clk  = clk;
  assign rom_addr = rom_addr_q;
  assign r_valid  = r_valid_q;
  assign r_q      = r_q_q;
  assign s_valid  = s_valid_q;
  assign s_q      = s_q_q;
  assign starved  = starved_q;
endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_font_rom_arbiter;
  localparam int AW   = 11;
  localparam int FW   = 8;
  localparam int LAT  = 2;
  localparam int SMAX = 15;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          r_req = 1'b0, s_req = 1'b0, clr_starved = 1'b0;
  logic [AW-1:0] r_addr = '0, s_addr = '0;
  logic          r_valid, s_ready, s_valid, starved, rom_clk;
  logic [FW-1:0] r_q, s_q, rom_q;
  logic [AW-1:0] rom_addr;
  logic [AW-1:0] rom_a1 = '0;
  logic [FW-1:0] rom_o = '0;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;
  int r_cnt = 0;
  logic [FW-1:0] s_log[$];

  always #5 clk = ~clk;

  // ROM: registered address, registered output, data = addr ^ 0xA5
  always @(posedge clk) begin
    rom_a1 <= rom_addr;
    rom_o  <= rom_a1[7:0] ^ 8'hA5;
  end
  assign rom_q = rom_o;

  font_rom_arbiter #(.ADDR_W(AW), .FONT_W(FW), .ROM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .r_req(r_req), .r_addr(r_addr), .r_valid(r_valid), .r_q(r_q),
    .s_req(s_req), .s_addr(s_addr), .s_ready(s_ready), .s_valid(s_valid), .s_q(s_q),
    .clr_starved(clr_starved), .starved(starved), .rom_clk(rom_clk), .rom_addr(rom_addr),
    .rom_q(rom_q)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending secondary addresses plus a list of scheduled returns.
  typedef struct {
    int          due;
    bit          is_r;
    logic [7:0]  d;
  } ret_t;

  ret_t          pend[$];
  logic [AW-1:0] mq[$];
  int            cyc = 0;
  int            m_wait = 0;
  bit            m_r_valid = 0, m_s_valid = 0, m_starved = 0, m_s_ready = 0;
  logic [7:0]    m_r_q = '0, m_s_q = '0;
  logic [AW-1:0] m_rom_addr = '0;

  initial begin
    bit            pre_empty, s_issue;
    logic [AW-1:0] a;
    ret_t          x;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend.delete(); mq.delete();
        m_wait = 0; m_r_valid = 0; m_s_valid = 0; m_starved = 0; m_s_ready = 0;
        m_r_q = '0; m_s_q = '0; m_rom_addr = '0;
      end else begin
        cyc++;
        pre_empty = (mq.size() == 0);
        s_issue   = 1'b0;
        if (r_req) begin
          pend.push_back('{cyc + LAT + 1, 1'b1, r_addr[7:0] ^ 8'hA5});
          m_rom_addr = r_addr;
        end else if (!pre_empty) begin
          a = mq.pop_front();
          pend.push_back('{cyc + LAT + 1, 1'b0, a[7:0] ^ 8'hA5});
          m_rom_addr = a;
          s_issue = 1'b1;
        end
        if (s_req && m_s_ready) mq.push_back(s_addr);
        if (pre_empty || s_issue) m_wait = 0;
        else if (m_wait < SMAX) m_wait++;
        if (clr_starved) m_starved = 0;
        else if (m_wait == SMAX) m_starved = 1;
        m_s_ready = (mq.size() < 2);
        m_r_valid = 0;
        m_s_valid = 0;
        while (pend.size() > 0 && pend[0].due == cyc) begin
          x = pend.pop_front();
          if (x.is_r) begin m_r_valid = 1; m_r_q = x.d; end
          else begin m_s_valid = 1; m_s_q = x.d; end
        end
      end
    end
  end

  // Compare process: every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("r_valid", int'(r_valid), int'(m_r_valid));
        chk("r_q", int'(r_q), int'(m_r_q));
        chk("s_valid", int'(s_valid), int'(m_s_valid));
        chk("s_q", int'(s_q), int'(m_s_q));
        chk("s_ready", int'(s_ready), int'(m_s_ready));
        chk("starved", int'(starved), int'(m_starved));
        chk("rom_addr", int'(rom_addr), int'(m_rom_addr));
        chk("rom_clk", int'(rom_clk), int'(clk));
        if (r_valid) r_cnt++;
        if (s_valid) s_log.push_back(s_q);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int   si, acc;
    bit   hs;
    logic [7:0] exp3 [3];
    exp3[0] = 8'hA4; exp3[1] = 8'hA7; exp3[2] = 8'hA6;
    chk_en = 1'b1;

    step(3);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_r_valid", int'(r_valid), 0);
    rst_n = 1'b1;
    step(1);
    chk("ready_after_rst", int'(s_ready), 1);
    step(2);

    // Single renderer read
    r_req = 1'b1; r_addr = 11'h010;
    step(1);
    r_req = 1'b0;
    step(2);
    chk("t1_early", int'(r_valid), 0);
    step(1);
    chk("t1_valid", int'(r_valid), 1);
    chk("t1_q", int'(r_q), 'hB5);
    step(1);
    chk("t1_pulse", int'(r_valid), 0);
    chk("t1_hold", int'(r_q), 'hB5);

    // Single secondary read
    chk("t2_ready", int'(s_ready), 1);
    s_req = 1'b1; s_addr = 11'h020;
    step(1);
    s_req = 1'b0;
    step(3);
    chk("t2_early", int'(s_valid), 0);
    step(1);
    chk("t2_valid", int'(s_valid), 1);
    chk("t2_q", int'(s_q), 'h85);
    step(2);

    // Continuous renderer traffic with three queued secondary requests
    r_cnt = 0; s_log.delete(); si = 0;
    for (int i = 0; i < 40; i++) begin
      r_req = 1'b1; r_addr = AW'($urandom_range(0, 2047));
      s_req = (si < 3); s_addr = AW'(si + 1);
      hs = s_req && s_ready;
      if (i == 4) chk("t3_held", int'(s_ready), 0);
      step(1);
      if (hs) si++;
    end
    r_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_req = (si < 3); s_addr = AW'(si + 1);
      hs = s_req && s_ready;
      step(1);
      if (hs) si++;
    end
    s_req = 1'b0;
    step(2);
    chk("t3_rcnt", r_cnt, 40);
    chk("t3_scnt", s_log.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < s_log.size()) chk("t3_order", int'(s_log[k]), int'(exp3[k]));
    end
    clr_starved = 1'b1;
    step(1);
    clr_starved = 1'b0;
    step(1);

    // Starvation flag timing
    r_req = 1'b1; r_addr = 11'h3FF; s_req = 1'b1; s_addr = 11'h155;
    step(1);
    s_req = 1'b0;
    step(14);
    chk("t4_not_yet", int'(starved), 0);
    step(1);
    chk("t4_set", int'(starved), 1);
    clr_starved = 1'b1;
    step(1);
    chk("t4_clr", int'(starved), 0);
    clr_starved = 1'b0;
    step(1);
    chk("t4_reset", int'(starved), 1);
    r_req = 1'b0;
    step(5);
    clr_starved = 1'b1;
    step(1);
    clr_starved = 1'b0;
    step(1);

    // Reset with two secondary reads and one renderer read in flight
    s_req = 1'b1; s_addr = 11'h100;
    step(1);
    s_addr = 11'h101;
    step(1);
    s_req = 1'b0;
    step(1);
    r_req = 1'b1; r_addr = 11'h222;
    step(1);
    r_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_r_valid", int'(r_valid), 0);
    chk("t5_s_valid", int'(s_valid), 0);
    chk("t5_r_q", int'(r_q), 0);
    chk("t5_s_q", int'(s_q), 0);
    chk("t5_rom_addr", int'(rom_addr), 0);
    chk("t5_s_ready", int'(s_ready), 0);
    step(2);
    rst_n = 1'b1;
    r_cnt = 0; s_log.delete();
    step(8);
    chk("t5_no_r", r_cnt, 0);
    chk("t5_no_s", s_log.size(), 0);

    // Alternating renderer traffic with a saturated secondary queue
    r_cnt = 0; s_log.delete(); acc = 0;
    s_req = 1'b1; s_addr = AW'($urandom_range(0, 2047));
    for (int i = 0; i < 40; i++) begin
      r_req = ((i % 2) == 0); r_addr = AW'($urandom_range(0, 2047));
      hs = s_req && s_ready;
      step(1);
      if (hs) begin
        acc++;
        s_addr = AW'($urandom_range(0, 2047));
      end
    end
    r_req = 1'b0; s_req = 1'b0;
    step(6);
    chk("t6_rcnt", r_cnt, 20);
    chk("t6_scnt", s_log.size(), acc);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      r_req = ($urandom_range(0, 3) != 0);
      r_addr = AW'($urandom_range(0, 2047));
      clr_starved = ($urandom_range(0, 15) == 0);
      if (!s_req) begin
        s_req = $urandom_range(0, 1) != 0;
        s_addr = AW'($urandom_range(0, 2047));
      end
      hs = s_req && s_ready;
      step(1);
      if (hs) begin
        s_req = $urandom_range(0, 1) != 0;
        s_addr = AW'($urandom_range(0, 2047));
      end
    end
    r_req = 1'b0; s_req = 1'b0; clr_starved = 1'b0;
    step(8);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
